// File: rtl/regfile_writeback_pkg.sv
// Shared types and defaults for the CR16 register-file writeback path.
package regfile_writeback_pkg;

  localparam int unsigned DefaultWidth        = 16;
  localparam int unsigned DefaultRegisterBits = 4;
  // r0 is hard-wired: writes to it are dropped and it is never pending
  localparam int unsigned ZeroRegister        = 0;

  typedef struct packed {
    logic [DefaultRegisterBits-1:0] address;
    logic [DefaultWidth-1:0]        data;
  } wb_entry_t;

endpackage

// File: rtl/regfile_writeback_if.sv
// Execute/memory-stage side of the writeback block: ALU, load, claim and write-port signals.
interface regfile_writeback_if #(
  parameter int unsigned WIDTH         = 16,
  parameter int unsigned REGISTER_BITS = 4
) ();

  logic                          aluValid;
  logic [REGISTER_BITS-1:0]      aluAddress;
  logic [WIDTH-1:0]              aluData;
  logic                          aluReady;
  logic                          loadValid;
  logic [REGISTER_BITS-1:0]      loadAddress;
  logic [WIDTH-1:0]              loadData;
  logic                          loadReady;
  logic                          claimValid;
  logic [REGISTER_BITS-1:0]      claimAddress;
  logic [2**REGISTER_BITS-1:0]   pendingMask;
  logic                          shouldWrite;
  logic [REGISTER_BITS-1:0]      writeAddress;
  logic [WIDTH-1:0]              writeData;

  modport master (
    output aluValid, aluAddress, aluData, loadValid, loadAddress, loadData,
           claimValid, claimAddress,
    input  aluReady, loadReady, pendingMask, shouldWrite, writeAddress, writeData
  );

  modport slave (
    input  aluValid, aluAddress, aluData, loadValid, loadAddress, loadData,
           claimValid, claimAddress,
    output aluReady, loadReady, pendingMask, shouldWrite, writeAddress, writeData
  );

endinterface

// File: rtl/regfile_writeback_fifo.sv
// Load-result FIFO: DEPTH entries (power of two), head visible combinationally.
module regfile_writeback_fifo #(
  parameter int unsigned ENTRY_BITS = 20,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  push,
  input  logic [ENTRY_BITS-1:0] push_entry,
  input  logic                  pop,
  output logic [ENTRY_BITS-1:0] head,
  output logic                  full,
  output logic                  empty
);

  localparam int unsigned PtrBits   = $clog2(DEPTH);
  localparam int unsigned CountBits = $clog2(DEPTH + 1);

  logic [PtrBits-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CountBits-1:0]  count_q;
  logic [ENTRY_BITS-1:0] mem_q [DEPTH];
  logic                  do_push, do_pop;

  assign full    = (count_q == CountBits'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem_q[rd_ptr_q];

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CountBits'(do_push) - CountBits'(do_pop);
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= push_entry;
  end

endmodule

// File: rtl/regfile_writeback.sv
// Register-file write-port arbiter: ALU results vs buffered loads, with starvation bound
// and a pending-load scoreboard for the issue stage.
module regfile_writeback
  import regfile_writeback_pkg::*;
#(
  parameter int unsigned WIDTH         = DefaultWidth,
  parameter int unsigned REGISTER_BITS = DefaultRegisterBits,
  parameter int unsigned LOAD_DEPTH    = 4,
  parameter int unsigned STARVE_LIMIT  = 8
) (
  input logic                clock,
  input logic                reset,
  regfile_writeback_if.slave bus
);

  localparam int unsigned EntryBits  = REGISTER_BITS + WIDTH;
  localparam int unsigned Registers  = 2 ** REGISTER_BITS;
  localparam int unsigned StarveBits = $clog2(STARVE_LIMIT + 1);
  localparam logic [StarveBits-1:0]    StarveMax = StarveBits'(STARVE_LIMIT);
  localparam logic [REGISTER_BITS-1:0] ZeroAddr  = REGISTER_BITS'(ZeroRegister);

  logic                     empty, full, starved;
  logic [EntryBits-1:0]     head;
  logic [REGISTER_BITS-1:0] head_address, win_address;
  logic [WIDTH-1:0]         head_data, win_data;
  logic                     load_wins, alu_ready, alu_grant, win_valid;
  logic [StarveBits-1:0]    starve_q, starve_d;
  logic [Registers-1:0]     pending_q, pending_d;
  logic                     should_write_q;
  logic [REGISTER_BITS-1:0] write_address_q;
  logic [WIDTH-1:0]         write_data_q;

  regfile_writeback_fifo #(
    .ENTRY_BITS (EntryBits),
    .DEPTH      (LOAD_DEPTH)
  ) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .push       (bus.loadValid),
    .push_entry ({bus.loadAddress, bus.loadData}),
    .pop        (load_wins),
    .head       (head),
    .full       (full),
    .empty      (empty)
  );

  assign head_address = head[EntryBits-1:WIDTH];
  assign head_data    = head[WIDTH-1:0];
  assign starved      = (starve_q == StarveMax);

  // Full or starved FIFO forces a load; otherwise ALU keeps priority
  assign load_wins = !empty && (full || starved || !bus.aluValid);
  assign alu_ready = !(full || (!empty && starved));
  assign alu_grant = bus.aluValid && alu_ready && !load_wins;
  assign win_valid = load_wins || alu_grant;

  always_comb begin
    win_address = load_wins ? head_address : bus.aluAddress;
    win_data    = load_wins ? head_data : bus.aluData;

    starve_d = starve_q;
    if (load_wins || empty) begin
      starve_d = '0;
    end else if (alu_grant && !starved) begin
      starve_d = starve_q + 1'b1;
    end

    // Claim applied after clear so a same-cycle claim on the same register wins
    pending_d = pending_q;
    if (load_wins) pending_d[head_address] = 1'b0;
    if (bus.claimValid && (bus.claimAddress != ZeroAddr)) pending_d[bus.claimAddress] = 1'b1;
    pending_d[ZeroAddr] = 1'b0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      starve_q        <= '0;
      pending_q       <= '0;
      should_write_q  <= 1'b0;
      write_address_q <= '0;
      write_data_q    <= '0;
    end else begin
      starve_q       <= starve_d;
      pending_q      <= pending_d;
      should_write_q <= win_valid && (win_address != ZeroAddr);
      if (win_valid) begin
        write_address_q <= win_address;
        write_data_q    <= win_data;
      end
    end
  end

  assign bus.aluReady     = alu_ready;
  assign bus.loadReady    = !full;
  assign bus.pendingMask  = pending_q;
  assign bus.shouldWrite  = should_write_q;
  assign bus.writeAddress = write_address_q;
  assign bus.writeData    = write_data_q;

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed bench for regfile_writeback: ALU/load paths, fill, starvation, r0 and async reset.
module tb_regfile_writeback;
  import regfile_writeback_pkg::*;

  logic clock;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  regfile_writeback_if #(.WIDTH(16), .REGISTER_BITS(4)) bus ();

  regfile_writeback #(
    .WIDTH         (16),
    .REGISTER_BITS (4),
    .LOAD_DEPTH    (4),
    .STARVE_LIMIT  (8)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    bus.aluValid     = 1'b0;
    bus.aluAddress   = '0;
    bus.aluData      = '0;
    bus.loadValid    = 1'b0;
    bus.loadAddress  = '0;
    bus.loadData     = '0;
    bus.claimValid   = 1'b0;
    bus.claimAddress = '0;
  endtask

  task automatic claim(input logic [3:0] addr);
    check("claim_not_pending", 32'(bus.pendingMask[addr]), 32'd0);
    bus.claimValid   = 1'b1;
    bus.claimAddress = addr;
    tick();
    bus.claimValid = 1'b0;
  endtask

  wb_entry_t fill [4];
  int        alu_writes;
  int        writes;
  logic      found;
  logic      ready_now;
  logic      ready_at_load;

  initial begin
    fill[0] = '{address: 4'd8,  data: 16'hA008};
    fill[1] = '{address: 4'd9,  data: 16'hA009};
    fill[2] = '{address: 4'd10, data: 16'hA00A};
    fill[3] = '{address: 4'd11, data: 16'hA00B};

    idle();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
    check("rst_should_write", 32'(bus.shouldWrite), 32'd0);
    check("rst_write_address", 32'(bus.writeAddress), 32'd0);
    check("rst_write_data", 32'(bus.writeData), 32'd0);
    check("rst_pending", 32'(bus.pendingMask), 32'd0);
    check("rst_alu_ready", 32'(bus.aluReady), 32'd1);
    check("rst_load_ready", 32'(bus.loadReady), 32'd1);

    // ALU only
    bus.aluValid = 1'b1; bus.aluAddress = 4'd3; bus.aluData = 16'h1234;
    check("alu_ready", 32'(bus.aluReady), 32'd1);
    tick();
    bus.aluValid = 1'b0;
    check("alu_should_write", 32'(bus.shouldWrite), 32'd1);
    check("alu_address", 32'(bus.writeAddress), 32'd3);
    check("alu_data", 32'(bus.writeData), 32'h1234);
    check("alu_ready_after", 32'(bus.aluReady), 32'd1);
    tick();
    check("alu_idle", 32'(bus.shouldWrite), 32'd0);

    // Load only: pushed N, written N+2, pending clears with the write
    claim(4'd5);
    check("load_pending_set", 32'(bus.pendingMask), 32'h0020);
    bus.loadValid = 1'b1; bus.loadAddress = 4'd5; bus.loadData = 16'hBEEF;
    tick();
    bus.loadValid = 1'b0;
    check("load_n1_no_write", 32'(bus.shouldWrite), 32'd0);
    check("load_n1_pending", 32'(bus.pendingMask), 32'h0020);
    tick();
    check("load_should_write", 32'(bus.shouldWrite), 32'd1);
    check("load_address", 32'(bus.writeAddress), 32'd5);
    check("load_data", 32'(bus.writeData), 32'hBEEF);
    check("load_pending_clear", 32'(bus.pendingMask), 32'd0);
    tick();

    // Starvation: one load behind continuous ALU traffic
    bus.aluValid = 1'b1; bus.aluAddress = 4'd2; bus.aluData = 16'h2000;
    bus.loadValid = 1'b1; bus.loadAddress = 4'd7; bus.loadData = 16'h7777;
    tick();
    bus.loadValid = 1'b0;
    check("starve_first_alu", 32'(bus.writeAddress), 32'd2);
    alu_writes = 0; found = 1'b0; ready_at_load = 1'b1;
    for (int c = 0; c < 20 && !found; c++) begin
      ready_now = bus.aluReady;
      tick();
      if (bus.shouldWrite && bus.writeAddress == 4'd2) alu_writes++;
      else begin
        found = 1'b1;
        ready_at_load = ready_now;
      end
    end
    check("starve_alu_writes", 32'(alu_writes), 32'd8);
    check("starve_load_address", 32'(bus.writeAddress), 32'd7);
    check("starve_load_data", 32'(bus.writeData), 32'h7777);
    check("starve_alu_blocked", 32'(ready_at_load), 32'd0);
    check("starve_alu_ready_back", 32'(bus.aluReady), 32'd1);

    // Fill the FIFO under continuous ALU traffic
    bus.aluAddress = 4'd1; bus.aluData = 16'h00F1;
    for (int i = 0; i < 4; i++) begin
      bus.loadValid = 1'b1; bus.loadAddress = fill[i].address; bus.loadData = fill[i].data;
      tick();
    end
    bus.loadValid = 1'b0;
    check("fill_last_alu", 32'(bus.writeAddress), 32'd1);
    check("fill_load_ready", 32'(bus.loadReady), 32'd0);
    check("fill_alu_ready", 32'(bus.aluReady), 32'd0);
    tick();
    check("fill_first_address", 32'(bus.writeAddress), 32'(fill[0].address));
    check("fill_first_data", 32'(bus.writeData), 32'(fill[0].data));
    check("fill_load_ready_back", 32'(bus.loadReady), 32'd1);
    check("fill_alu_ready_back", 32'(bus.aluReady), 32'd1);
    for (int k = 1; k < 4; k++) begin
      alu_writes = 0; found = 1'b0;
      for (int c = 0; c < 20 && !found; c++) begin
        tick();
        if (bus.shouldWrite && bus.writeAddress == 4'd1) alu_writes++;
        else found = 1'b1;
      end
      check("drain_alu_writes", 32'(alu_writes), 32'd8);
      check("drain_address", 32'(bus.writeAddress), 32'(fill[k].address));
      check("drain_data", 32'(bus.writeData), 32'(fill[k].data));
    end
    bus.aluValid = 1'b0;
    tick();

    // Register 0: accepted but never written, never pending
    bus.aluValid = 1'b1; bus.aluAddress = 4'd0; bus.aluData = 16'h5555;
    check("r0_alu_ready", 32'(bus.aluReady), 32'd1);
    tick();
    bus.aluValid = 1'b0;
    check("r0_alu_dropped", 32'(bus.shouldWrite), 32'd0);
    bus.loadValid = 1'b1; bus.loadAddress = 4'd0; bus.loadData = 16'h6666;
    tick();
    bus.loadValid = 1'b1; bus.loadAddress = 4'd6; bus.loadData = 16'h0606;
    tick();
    bus.loadValid = 1'b0;
    check("r0_load_dropped", 32'(bus.shouldWrite), 32'd0);
    tick();
    check("r0_next_load_write", 32'(bus.shouldWrite), 32'd1);
    check("r0_next_load_address", 32'(bus.writeAddress), 32'd6);
    check("r0_next_load_data", 32'(bus.writeData), 32'h0606);
    claim(4'd0);
    check("r0_claim_ignored", 32'(bus.pendingMask), 32'd0);

    // Asynchronous reset with loads queued and registers pending
    claim(4'd5);
    claim(4'd6);
    claim(4'd7);
    check("rst2_pending", 32'(bus.pendingMask), 32'h00E0);
    bus.aluValid = 1'b1; bus.aluAddress = 4'd2; bus.aluData = 16'h2222;
    for (int i = 5; i < 8; i++) begin
      bus.loadValid = 1'b1; bus.loadAddress = 4'(i); bus.loadData = 16'(16'hC000 + i);
      tick();
    end
    idle();
    check("rst2_alu_write", 32'(bus.shouldWrite), 32'd1);
    reset = 1'b1;
    #1;
    check("rst2_should_write", 32'(bus.shouldWrite), 32'd0);
    check("rst2_write_address", 32'(bus.writeAddress), 32'd0);
    check("rst2_write_data", 32'(bus.writeData), 32'd0);
    check("rst2_pending_clear", 32'(bus.pendingMask), 32'd0);
    check("rst2_load_ready", 32'(bus.loadReady), 32'd1);
    check("rst2_alu_ready", 32'(bus.aluReady), 32'd1);
    tick();
    tick();
    reset = 1'b0;
    writes = 0;
    repeat (6) begin
      tick();
      if (bus.shouldWrite) writes++;
    end
    check("rst2_no_stale_writes", 32'(writes), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/regfile_writeback.md
# regfile_writeback

Write-port arbiter and load-result buffer for the CR16 register file: merges single-cycle ALU results and variable-latency memory load results onto the register file's single write port (shouldWrite / writeAddress / writeData). Holds a small FIFO of load results, gives ALU results priority with bounded starvation, and keeps a pending-load scoreboard so the issue stage can stall on registers whose load has not yet written back. Sits between execute/memory stages and the register file.

## Interface
- WIDTH, 16, data width (matches register file)
- REGISTER_BITS, 4, register address width (2^REGISTER_BITS registers)
- LOAD_DEPTH, 4, load-result FIFO entries (power of two, ≥2)
- STARVE_LIMIT, 8, consecutive ALU grants allowed while a load waits

Ports:
- clock  in  1  single clock, all state on posedge
- reset  in  1  asynchronous, active-high; clears all state
- aluValid  in  1  ALU result present
- aluAddress  in  REGISTER_BITS  destination register
- aluData  in  WIDTH  result
- aluReady  out  1  ALU result accepted this cycle when aluValid && aluReady
- loadValid  in  1  load result present
- loadAddress  in  REGISTER_BITS  destination register
- loadData  in  WIDTH  loaded data
- loadReady  out  1  FIFO not full
- claimValid  in  1  issue stage launching a load
- claimAddress  in  REGISTER_BITS  load destination being claimed
- pendingMask  out  2^REGISTER_BITS  bit i set while a load to register i is outstanding
- shouldWrite  out  1  register file write enable (registered)
- writeAddress  out  REGISTER_BITS  register file write address (registered)
- writeData  out  WIDTH  register file write data (registered)

## Operation
- Load handshake: loadValid && loadReady pushes {loadAddress, loadData} into FIFO. loadReady = !full (no push-when-full even with same-cycle pop).
- Arbitration each cycle, with E = FIFO empty, F = FIFO full, S = (starveCount == STARVE_LIMIT):
  - loadWins = !E && (F || S || !aluValid); pops FIFO head.
  - aluReady = !(F || (!E && S)); independent of aluValid.
  - Else ALU wins when aluValid && aluReady.
- Winner's address/data registered onto write outputs; shouldWrite = 1 next cycle, except address 0 is dropped (shouldWrite = 0, entry still consumed/accepted).
- starveCount: +1 (saturating at STARVE_LIMIT) when ALU granted while !E; cleared when a load pops or FIFO empty.
- Scoreboard: claimValid sets pendingMask[claimAddress]; load writeback commit clears pendingMask[writeAddress of the popped entry]. Same cycle set and clear on same register → set wins. Claims to register 0 ignored; bit 0 always 0.
- Issue stage must not claim an already-pending register; bench asserts this.

## Timing
- Reset values: shouldWrite 0, writeAddress 0, writeData 0, pendingMask 0, FIFO empty, starveCount 0; hence aluReady 1, loadReady 1 after reset.
- Reset mid-operation: FIFO contents and pending bits discarded; shouldWrite drops immediately (async).
- ALU latency: accepted cycle N → shouldWrite high cycle N+1.
- Load latency: no bypass; pushed cycle N → earliest pop N+1 → shouldWrite N+2.
- Pending bit clears in the pop cycle (visible N+2 registered mask, aligned with the write).
- FIFO full: ALU stalled (aluReady 0) until a pop frees a slot; loadReady rises the cycle after the pop.
- Push and pop same cycle when not full: count unchanged.
- Throughput: one register write per cycle max.

## Structure
- Shared package: WIDTH/REGISTER_BITS defaults, writeback entry struct {address, data}, zero-register constant.
- Sub-module: regfile_writeback_fifo (LOAD_DEPTH-entry synchronous FIFO, count, full/empty, async reset); arbiter, starve counter, scoreboard, output register in top.

## Test plan
- ALU only: aluValid with address 3, data 0x1234 → next cycle shouldWrite 1, writeAddress 3, writeData 0x1234; aluReady stays 1.
- Load only: claim r5, load r5 = 0xBEEF at N → pendingMask bit 5 set; shouldWrite at N+2 with 0xBEEF; bit 5 clear after.
- Fill: aluValid held every cycle, push 4 loads → loadReady 0 at count 4, aluReady 0 the full cycle, load written, then loads drain one per STARVE_LIMIT ALU grants.
- Starvation: continuous ALU traffic, one load queued → load written after exactly 8 ALU writes; aluReady low that one cycle.
- Register 0: ALU and load to r0 → accepted, shouldWrite stays 0; claim r0 → pendingMask unchanged.
- Reset with 3 loads queued and pendingMask 0x00E0 → all outputs 0 immediately; no queued load written afterward.
